force_spike_encoder: RTL
========================

Name: force_spike_encoder

Overview:
- Inverse of the muscle path. The muscle turns spike counts into float force; this block turns a float firing rate into spikes.
- The rate input is derived from force or length, for example a Golgi tendon or spindle afferent drive.
- Each enabled clock it adds the rate to an integrate-and-fire phase accumulator and emits spikes.
- On every frame tick it reports the spike count for the frame, in the i_spike_cnt format the muscle input expects.

Parameters:
- FRAC_BITS, 16, fractional bits of the internal unsigned rate/accumulator format (value 1.0 = 1<<FRAC_BITS).
- CNT_W, 32, width of the frame spike counter and of o_spike_cnt.
- REFRACT_CYCLES, 3, hold-off cycles after each spike (used only with REFRACTORY_EN).

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk
- en  in  1  integrate enable; low freezes the accumulator
- f_rate  in  32  IEEE-754 single, spikes per clock
- frame_tick  in  1  one-cycle pulse that closes the current counting frame
- o_spike  out  1  registered spike, high for one cycle per spike
- o_spike_cnt  out  CNT_W  spike count of the last closed frame, unsigned integer
- o_cnt_valid  out  1  one-cycle pulse when o_spike_cnt updates

Behaviour:
- Reset: rate_q, acc, cnt, o_spike, o_spike_cnt and o_cnt_valid all go to 0; state goes to INTEGRATE. Reset mid-frame discards the partial count and emits no o_cnt_valid.
- Stage 1, every clock regardless of en: rate_q <= to_q(f_rate). Conversion rules:
  - sign=1, NaN, zero or denormal -> 0.
  - +inf or value >= 1.0 -> 1<<FRAC_BITS (saturate).
  - Otherwise {1,mant} >> (150-FRAC_BITS-exp), truncating toward zero.
  - exp <= 126-FRAC_BITS-1 -> 0.
- Stage 2, accumulator is FRAC_BITS+2 bits wide:
  - If en and state INTEGRATE: sum = acc + rate_q.
  - If sum >= 1<<FRAC_BITS: spike_nxt=1 and acc <= sum - (1<<FRAC_BITS). Otherwise spike_nxt=0 and acc <= sum.
  - Invariant: acc < 1.0, so at most one spike per clock.
  - When en=0: acc holds and spike_nxt=0.
  - o_spike <= spike_nxt.
- Latency: a change on f_rate first affects o_spike 2 rising edges later.
- Counter:
  - cnt <= cnt + spike_nxt, saturating at 2^CNT_W-1 (no wrap).
  - On an edge where frame_tick=1: o_spike_cnt <= sat(cnt + spike_nxt); cnt <= 0; o_cnt_valid <= 1.
  - o_cnt_valid is 0 on all other edges.
- Simultaneous spike and frame_tick: the spike belongs to the closing frame.
- frame_tick on consecutive cycles: the second report is 0 or 1 (only that cycle's spike).
- frame_tick while en=0: the report is still produced.
- States: INTEGRATE and REFRACT. REFRACT is reachable only with REFRACTORY_EN; without it the block stays in INTEGRATE.

Optional Feature:
- Macro: FORCE_SPIKE_REFRACTORY_EN.
- Defined:
  - An edge with spike_nxt=1 moves INTEGRATE -> REFRACT and loads rcnt <= REFRACT_CYCLES-1.
  - In REFRACT: acc holds, spike_nxt=0, rcnt decrements (counting only when en=1). At rcnt==0 the state returns to INTEGRATE on the next edge.
  - REFRACT_CYCLES=0 behaves as if the macro were undefined.
  - Maximum rate is 1/(REFRACT_CYCLES+1) spikes per clock.
- Undefined: no state register and no rcnt; spikes are limited only by the rate.

Decomposition:
- Package force_spike_pkg holds:
  - FRAC_BITS default, ONE_Q = 1<<FRAC_BITS;
  - the IEEE-754 field constants: bias 127, exp all-ones 255, mantissa width 23;
  - state enum {INTEGRATE, REFRACT}.
- One sub-module, float_to_uq (purely combinational): implements the conversion and saturation rules. The registering happens in the parent.

Test Plan:
- f_rate=0x3F000000 (0.5), en=1, frame_tick every 100 clocks -> from the second frame on, o_spike_cnt=50 with o_cnt_valid a single pulse; o_spike alternates 0/1.
- f_rate=0x3F800000 (1.0), then 0x40000000 (2.0), then 0x7F800000 (+inf) -> o_spike high every cycle; each frame reports 100.
- f_rate=0xBF000000 (-0.5), 0x7FC00000 (NaN), 0x00000001 (denormal) -> o_spike never asserts; frames report 0.
- f_rate=0x3E800000 (0.25), en low for cycles 40-59 of each 100-cycle frame -> 20 per frame; acc value identical before and after each gap.
- rate 1.0, reset asserted at cycle 37 of a frame for 2 cycles -> all outputs 0 and no o_cnt_valid for that frame. Next frame_tick reports the spikes since reset release minus 2-cycle pipeline fill. Also: frame_tick on consecutive cycles -> reports 100 then 1.
- FORCE_SPIKE_REFRACTORY_EN defined, REFRACT_CYCLES=3, rate 1.0 -> spikes exactly every 4 cycles, frame report 25.

Source files
------------

// File: rtl/force_spike_pkg.sv
// -----------------------------------------------------------------------------
// force_spike_pkg
// Shared constants and types for the force/rate-to-spike encoder.
//   FRAC_BITS_DEFAULT : fractional bits of the unsigned rate/accumulator format
//   ONE_Q             : the value 1.0 in that format (1 << FRAC_BITS_DEFAULT)
//   FP_*              : IEEE-754 single-precision field constants
//   enc_state_e       : integrate / refractory state of the encoder
// Optional feature macro used by the encoder: FORCE_SPIKE_REFRACTORY_EN
// -----------------------------------------------------------------------------
package force_spike_pkg;

   localparam int FRAC_BITS_DEFAULT = 16;
   localparam logic [FRAC_BITS_DEFAULT:0] ONE_Q = {1'b1, {FRAC_BITS_DEFAULT{1'b0}}};

   localparam int FP_BIAS    = 127;
   localparam int FP_EXP_MAX = 255;
   localparam int FP_MANT_W  = 23;

   typedef enum logic [0:0] {
      INTEGRATE = 1'b0,
      REFRACT   = 1'b1
   } enc_state_e;

endpackage

// File: rtl/force_spike_encoder_float_to_uq.sv
// -----------------------------------------------------------------------------
// float_to_uq
// Combinational conversion of an IEEE-754 single into an unsigned fixed-point
// rate with FRAC_BITS fractional bits, saturated to 1.0.
//   f_i : IEEE-754 single, spikes per clock
//   q_o : unsigned rate, FRAC_BITS+1 bits (1.0 = 1 << FRAC_BITS)
// Negative values, NaN, zero and denormals map to 0; +inf and values >= 1.0
// saturate to 1.0; everything else is truncated toward zero.
// -----------------------------------------------------------------------------
module float_to_uq
   import force_spike_pkg::*;
#(
   parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
   input  logic [31:0]        f_i,
   output logic [FRAC_BITS:0] q_o
);

   localparam int                  WIDE_W = FP_MANT_W + 1 + FRAC_BITS;
   localparam logic [FRAC_BITS:0]  ONE    = {1'b1, {FRAC_BITS{1'b0}}};

   logic                  sign_s;
   logic [7:0]            exp_s;
   logic [FP_MANT_W-1:0]  mant_s;
   logic [7:0]            shamt_s;
   logic [WIDE_W-1:0]     wide_s;

   assign sign_s = f_i[31];
   assign exp_s  = f_i[30:23];
   assign mant_s = f_i[22:0];

   // Field decode and scaling. The significand is pre-shifted left by
   // FRAC_BITS so the right shift (150 - exp) is never negative for any
   // exponent below the bias, whatever FRAC_BITS is.
   always_comb begin
      q_o     = '0;
      shamt_s = 8'd0;
      wide_s  = '0;
      if (sign_s || (exp_s == 8'd0)) begin
         q_o = '0;
      end else if (exp_s == 8'(FP_EXP_MAX)) begin
         q_o = (mant_s == '0) ? ONE : '0;
      end else if (exp_s >= 8'(FP_BIAS)) begin
         q_o = ONE;
      end else begin
         shamt_s = 8'(FP_BIAS + FP_MANT_W) - exp_s;
         wide_s  = {1'b1, mant_s, {FRAC_BITS{1'b0}}} >> shamt_s;
         // value is < 1.0 here, so only the low FRAC_BITS+1 bits can be set
         q_o     = (FRAC_BITS + 1)'(wide_s);
      end
   end

endmodule

// File: rtl/force_spike_encoder.sv
// -----------------------------------------------------------------------------
// force_spike_encoder
// Integrate-and-fire encoder turning a float firing rate into a spike train
// and a per-frame spike count in the muscle's spike-count input format.
//   clk          : system clock
//   reset        : synchronous active-high reset
//   en           : integrate enable, low freezes the accumulator
//   f_rate       : IEEE-754 single, spikes per clock
//   frame_tick   : one-cycle pulse closing the current counting frame
//   o_spike      : registered one-cycle spike
//   o_spike_cnt  : spike count of the last closed frame (saturating)
//   o_cnt_valid  : one-cycle pulse when o_spike_cnt updates
// Optional feature: define FORCE_SPIKE_REFRACTORY_EN to add a hold-off of
// REFRACT_CYCLES enabled cycles after each spike.
// -----------------------------------------------------------------------------
module force_spike_encoder
   import force_spike_pkg::*;
#(
   parameter int FRAC_BITS      = FRAC_BITS_DEFAULT,
   parameter int CNT_W          = 32,
   parameter int REFRACT_CYCLES = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [31:0]      f_rate,
   input  logic             frame_tick,
   output logic             o_spike,
   output logic [CNT_W-1:0] o_spike_cnt,
   output logic             o_cnt_valid
);

   localparam int                 ACC_W = FRAC_BITS + 2;
   localparam logic [ACC_W-1:0]   ONE_W = {2'b01, {FRAC_BITS{1'b0}}};

   // Saturating add of a single spike to the frame counter.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c,
                                                input logic             s);
      if (s && (c != {CNT_W{1'b1}})) begin
         return c + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         return c;
      end
   endfunction

   logic [FRAC_BITS:0] rate_s;
   logic [FRAC_BITS:0] rate_q;
   logic [ACC_W-1:0]   acc_q;
   logic [ACC_W-1:0]   acc_d;
   logic [ACC_W-1:0]   sum_s;
   logic               spike_nxt_s;
   logic               integrate_s;
   logic [CNT_W-1:0]   cnt_q;
   logic [CNT_W-1:0]   cnt_inc_s;
   logic               spike_q;
   logic [CNT_W-1:0]   spike_cnt_q;
   logic               cnt_valid_q;

   float_to_uq #(
      .FRAC_BITS (FRAC_BITS)
   ) u_float_to_uq (
      .f_i (f_rate),
      .q_o (rate_s)
   );

`ifdef FORCE_SPIKE_REFRACTORY_EN
   localparam int RC_W = (REFRACT_CYCLES > 1) ? $clog2(REFRACT_CYCLES) : 1;

   enc_state_e       state_q;
   enc_state_e       state_d;
   logic [RC_W-1:0]  rcnt_q;
   logic [RC_W-1:0]  rcnt_d;

   assign integrate_s = (state_q == INTEGRATE);

   // Refractory state machine next state; REFRACT_CYCLES == 0 never leaves
   // INTEGRATE, matching the build without the feature.
   always_comb begin
      state_d = state_q;
      rcnt_d  = rcnt_q;
      case (state_q)
         INTEGRATE: begin
            if (spike_nxt_s && (REFRACT_CYCLES != 0)) begin
               state_d = REFRACT;
               rcnt_d  = RC_W'(REFRACT_CYCLES - 1);
            end else begin
               state_d = INTEGRATE;
            end
         end
         REFRACT: begin
            if (rcnt_q == '0) begin
               state_d = INTEGRATE;
            end else if (en) begin
               rcnt_d = rcnt_q - {{(RC_W-1){1'b0}}, 1'b1};
            end else begin
               rcnt_d = rcnt_q;
            end
         end
         default: begin
            state_d = INTEGRATE;
            rcnt_d  = '0;
         end
      endcase
   end

   // Refractory state and hold-off counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= INTEGRATE;
         rcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         rcnt_q  <= rcnt_d;
      end
   end
`else
   assign integrate_s = 1'b1;
`endif

   // Phase accumulator: acc stays below 1.0, so at most one spike per clock.
   always_comb begin
      sum_s       = acc_q + {1'b0, rate_q};
      spike_nxt_s = 1'b0;
      acc_d       = acc_q;
      if (en && integrate_s) begin
         if (sum_s >= ONE_W) begin
            spike_nxt_s = 1'b1;
            acc_d       = sum_s - ONE_W;
         end else begin
            acc_d       = sum_s;
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // A spike on the frame-closing edge is counted into the closing frame.
   assign cnt_inc_s = sat_inc(cnt_q, spike_nxt_s);

   // Rate register, accumulator, spike output and frame counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         rate_q      <= '0;
         acc_q       <= '0;
         spike_q     <= 1'b0;
         cnt_q       <= '0;
         spike_cnt_q <= '0;
         cnt_valid_q <= 1'b0;
      end else begin
         rate_q  <= rate_s;
         acc_q   <= acc_d;
         spike_q <= spike_nxt_s;
         if (frame_tick) begin
            spike_cnt_q <= cnt_inc_s;
            cnt_q       <= '0;
            cnt_valid_q <= 1'b1;
         end else begin
            cnt_q       <= cnt_inc_s;
            cnt_valid_q <= 1'b0;
         end
      end
   end

   assign o_spike     = spike_q;
   assign o_spike_cnt = spike_cnt_q;
   assign o_cnt_valid = cnt_valid_q;

endmodule
